sd_cmd_seq: RTL and testbench
=============================

# sd_cmd_seq

SD-card command sequencer that drives the SPI byte engine on behalf of software or a boot loader. It takes one command request, covering index, argument and extra response length. It frames the 6-byte SPI-mode SD command with a computed CRC7, polls for the R1 response, collects up to 4 trailing response bytes (R3/R7), and controls chip select. It sits between the CPU-side command registers and the byte-level SPI shifter, which it owns exclusively while busy.

## Interface
- NCR_MAX, 8: maximum 0xFF poll bytes sent while waiting for R1 before timeout (1..255).
- INIT_BYTES, 10: 0xFF bytes sent with CS deasserted when an init request is issued (10 = 80 clocks).
- i_clk  in  1  system clock; single clock domain.
- i_rst  in  1  synchronous, active-high reset.
- i_cmd_valid  in  1  command request; accepted when o_cmd_ready=1 in the same cycle.
- o_cmd_ready  out  1  high only in IDLE.
- i_cmd_init  in  1  sampled at accept; 1 = run the power-up clock sequence before the command.
- i_cmd_idx  in  6  command index.
- i_cmd_arg  in  32  command argument, sent MSB first.
- i_resp_len  in  3  extra response bytes after R1, 0..4; values 5..7 are treated as 4.
- o_done  out  1  one-cycle pulse when the sequence completes, including on timeout.
- o_r1  out  8  R1 byte; 0xFF on timeout.
- o_resp  out  32  extra response bytes, first received in the MSB; unused low bytes are 0.
- o_timeout  out  1  valid with o_done; 1 if no R1 was received within NCR_MAX polls.
- o_cs_n  out  1  SD chip select, active low.
- o_byte_stb  out  1  one-cycle request to the byte engine to shift o_byte_tx.
- o_byte_tx  out  8  byte to transmit; held stable from stb until done.
- i_byte_done  in  1  one-cycle pulse; byte transfer finished, i_byte_rx valid.
- i_byte_rx  in  8  byte received during the finished transfer.

## Operation
- States: IDLE, INIT, PRE, SEND, POLL, RESP, TAIL, FIN.
- IDLE: o_cs_n=1. On accept, latch idx, arg, resp_len and init. Next state is INIT if init=1, otherwise PRE.
- INIT: o_cs_n=1. Send INIT_BYTES bytes of 0xFF, then go to PRE.
- PRE: o_cs_n=0. Send one 0xFF, then go to SEND.
- SEND: o_cs_n=0. Send 6 bytes in this order:
  - {2'b01, idx}
  - arg[31:24], arg[23:16], arg[15:8], arg[7:0]
  - {crc7, 1'b1}
- CRC7: polynomial x^7+x^3+1, initial value 0, computed over the first 5 bytes MSB first. It is updated bytewise or bitwise as each byte is issued, and must be final before byte 6 is strobed.
- POLL: send 0xFF. On each done:
  - If i_byte_rx[7]=0: latch o_r1. Go to RESP if resp_len>0, otherwise TAIL.
  - Else increment the poll count. If the count reaches NCR_MAX: set r1=0xFF and timeout=1, then go to TAIL.
- RESP: send resp_len bytes of 0xFF. Shift each received byte into o_resp, so 4 bytes B0..B3 give {B0,B1,B2,B3}. Then go to TAIL.
- TAIL: raise o_cs_n=1, then send one 0xFF (8 clocks with CS high). Then go to FIN.
- FIN: pulse o_done, update o_timeout, go to IDLE.
- Byte-engine handshake:
  - Exactly one o_byte_stb per byte.
  - The next stb may not issue before the i_byte_done of the previous byte has been seen.
  - i_byte_done outside an outstanding transfer is ignored.
- o_r1, o_resp and o_timeout hold their values until the next accept. o_resp is cleared to 0 at accept.
- i_cmd_valid while busy is ignored (not queued).
- Reset at any point:
  - Return to IDLE; abandon the in-flight byte.
  - o_cs_n=1, o_byte_stb=0, o_done=0, o_timeout=0, o_r1=0xFF, o_resp=0, o_byte_tx=0xFF.
  - o_cmd_ready=1 from the first cycle after reset.

## Timing
- Accept cycle T: the first o_byte_stb issues at T+1 or later, at most at T+2.
- stb-to-stb gap: at least 1 cycle after i_byte_done, at most 2.
- o_cs_n changes only while no transfer is outstanding. It is stable at least 1 cycle before the stb of the first byte in PRE and in TAIL.
- o_done asserts 1–2 cycles after i_byte_done of the TAIL byte. o_cmd_ready returns the cycle after o_done.
- Byte count with init=0: 1 + 6 + polls + resp_len + 1. A 1-poll R1 with resp_len=0 therefore uses 9 transfers.

## Test plan
- CMD0, arg 0, init=1, card answers 0x01 on poll 2 -> 10 bytes of 0xFF with CS high, then FF 40 00 00 00 00 95 with CS low; o_r1=0x01, o_timeout=0, o_resp=0.
- CMD8, arg 0x000001AA, resp_len=4, card returns 0x01 then 00 00 01 AA -> bytes 48 00 00 01 AA 87 are sent; o_r1=0x01, o_resp=0x000001AA.
- CMD17, arg 0x12345678, card always returns 0xFF -> exactly NCR_MAX poll bytes, then TAIL; o_r1=0xFF, o_timeout=1; CS high before the last byte.
- Back-to-back CMD55 then CMD41, with i_cmd_valid held high -> the second command is accepted only when o_cmd_ready is high after o_done; no stb overlap; each command is framed by its own PRE/TAIL.
- Reset asserted mid-SEND, after byte 3 -> next cycle o_cs_n=1, o_cmd_ready=1, and no further stb. A stray i_byte_done afterwards is ignored. A new CMD0 then runs cleanly.
- Delayed i_byte_done (0–20 cycle random latency) -> o_byte_tx is stable between stb and done; never two stbs without an intervening done.

Source files
------------

// File: rtl/sd_cmd_seq_if.sv
// Command-register and byte-engine signals of the SD command sequencer.
// The slave modport is the sequencer side; the master modport is the CPU plus byte engine side.
interface sd_cmd_seq_if;
  logic        i_cmd_valid;
  logic        o_cmd_ready;
  logic        i_cmd_init;
  logic [5:0]  i_cmd_idx;
  logic [31:0] i_cmd_arg;
  logic [2:0]  i_resp_len;
  logic        o_done;
  logic [7:0]  o_r1;
  logic [31:0] o_resp;
  logic        o_timeout;
  logic        o_cs_n;
  logic        o_byte_stb;
  logic [7:0]  o_byte_tx;
  logic        i_byte_done;
  logic [7:0]  i_byte_rx;

  modport slave (
    input  i_cmd_valid, i_cmd_init, i_cmd_idx, i_cmd_arg, i_resp_len, i_byte_done, i_byte_rx,
    output o_cmd_ready, o_done, o_r1, o_resp, o_timeout, o_cs_n, o_byte_stb, o_byte_tx
  );

  modport master (
    output i_cmd_valid, i_cmd_init, i_cmd_idx, i_cmd_arg, i_resp_len, i_byte_done, i_byte_rx,
    input  o_cmd_ready, o_done, o_r1, o_resp, o_timeout, o_cs_n, o_byte_stb, o_byte_tx
  );
endinterface

// File: rtl/sd_cmd_seq.sv
// SD SPI-mode command sequencer: frames CMD+CRC7, polls R1, gathers up to 4 response bytes, drives CS.
// First stb 1-2 cycles after accept; one byte outstanding at a time, next stb waits for i_byte_done.
module sd_cmd_seq #(
  parameter int NCR_MAX    = 8,
  parameter int INIT_BYTES = 10
) (
  input logic         i_clk,
  input logic         i_rst,
  sd_cmd_seq_if.slave bus
);
  typedef enum logic [2:0] {IDLE, INIT, PRE, SEND, POLL, RESP, TAIL, FIN} state_t;

  state_t      state, state_nxt;
  logic [7:0]  cnt;
  logic        pend, fresh, cs_n_q;
  logic [5:0]  idx_q;
  logic [31:0] arg_q;
  logic [2:0]  rlen_q;
  logic [6:0]  crc_q;
  logic [7:0]  r1_q;
  logic [31:0] resp_q;
  logic        to_q;

  logic        accept, xfer_done, stb, sending;
  logic [7:0]  tx;

  function automatic logic [6:0] crc7_upd(input logic [6:0] c, input logic [7:0] d);
    logic [6:0] r;
    logic       fb;
    r = c;
    for (int i = 7; i >= 0; i--) begin
      fb = r[6] ^ d[i];
      r  = {r[5:0], 1'b0} ^ (fb ? 7'h09 : 7'h00);
    end
    return r;
  endfunction

  always_ff @(posedge i_clk) begin
    if (i_rst) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    accept    = (state == IDLE) && bus.i_cmd_valid;
    xfer_done = pend && bus.i_byte_done;
    sending   = state inside {INIT, PRE, SEND, POLL, RESP, TAIL};
    // A freshly entered state waits one cycle so CS settles before its first byte.
    stb       = sending && !pend && !fresh;
    tx        = 8'hFF;
    if (state == SEND) begin
      case (cnt[2:0])
        3'd0:    tx = {2'b01, idx_q};
        3'd1:    tx = arg_q[31:24];
        3'd2:    tx = arg_q[23:16];
        3'd3:    tx = arg_q[15:8];
        3'd4:    tx = arg_q[7:0];
        3'd5:    tx = {crc_q, 1'b1};
        default: tx = 8'hFF;
      endcase
    end
    case (state)
      IDLE: if (accept) state_nxt = bus.i_cmd_init ? INIT : PRE;
      INIT: if (xfer_done && cnt == 8'(INIT_BYTES - 1)) state_nxt = PRE;
      PRE:  if (xfer_done) state_nxt = SEND;
      SEND: if (xfer_done && cnt == 8'd5) state_nxt = POLL;
      POLL: if (xfer_done) begin
              if (!bus.i_byte_rx[7])                state_nxt = (rlen_q != 3'd0) ? RESP : TAIL;
              else if (cnt == 8'(NCR_MAX - 1))      state_nxt = TAIL;
            end
      RESP: if (xfer_done && cnt == {5'd0, rlen_q - 3'd1}) state_nxt = TAIL;
      TAIL: if (xfer_done) state_nxt = FIN;
      FIN:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      cnt    <= 8'd0;
      pend   <= 1'b0;
      fresh  <= 1'b0;
      cs_n_q <= 1'b1;
      idx_q  <= 6'd0;
      arg_q  <= 32'd0;
      rlen_q <= 3'd0;
      crc_q  <= 7'd0;
      r1_q   <= 8'hFF;
      resp_q <= 32'd0;
      to_q   <= 1'b0;
    end else begin
      // State changes only happen with no byte outstanding, so CS never moves mid-transfer.
      cs_n_q <= !(state_nxt inside {PRE, SEND, POLL, RESP});
      fresh  <= (state_nxt != state);
      if (stb)            pend <= 1'b1;
      else if (xfer_done) pend <= 1'b0;
      if (state_nxt != state) cnt <= 8'd0;
      else if (xfer_done)     cnt <= cnt + 8'd1;
      if (stb && state == SEND && cnt < 8'd5) crc_q <= crc7_upd(crc_q, tx);
      if (accept) begin
        idx_q  <= bus.i_cmd_idx;
        arg_q  <= bus.i_cmd_arg;
        rlen_q <= (bus.i_resp_len > 3'd4) ? 3'd4 : bus.i_resp_len;
        crc_q  <= 7'd0;
        resp_q <= 32'd0;
        to_q   <= 1'b0;
      end
      if (xfer_done && state == POLL) begin
        if (!bus.i_byte_rx[7]) r1_q <= bus.i_byte_rx;
        else if (cnt == 8'(NCR_MAX - 1)) begin
          r1_q <= 8'hFF;
          to_q <= 1'b1;
        end
      end
      if (xfer_done && state == RESP) begin
        case (cnt[1:0])
          2'd0: resp_q[31:24] <= bus.i_byte_rx;
          2'd1: resp_q[23:16] <= bus.i_byte_rx;
          2'd2: resp_q[15:8]  <= bus.i_byte_rx;
          2'd3: resp_q[7:0]   <= bus.i_byte_rx;
        endcase
      end
    end
  end

  assign bus.o_cmd_ready = (state == IDLE);
  assign bus.o_done      = (state == FIN);
  assign bus.o_r1        = r1_q;
  assign bus.o_resp      = resp_q;
  assign bus.o_timeout   = to_q;
  assign bus.o_cs_n      = cs_n_q;
  assign bus.o_byte_stb  = stb;
  assign bus.o_byte_tx   = tx;
endmodule

// File: tb/tb_sd_cmd_seq.sv
// Bench for sd_cmd_seq: table of SD commands, hand-written back-to-back/reset sequences, random commands.
// A card/byte-engine responder answers every stb after a random latency and logs each transfer.
module tb_sd_cmd_seq;
  localparam int NCR_MAX    = 8;
  localparam int INIT_BYTES = 10;
  localparam int NX         = 4096;

  typedef struct {
    bit          init;
    logic [5:0]  idx;
    logic [31:0] arg;
    logic [2:0]  len;
    int          k;      // 0xFF polls the card returns before R1
    logic [7:0]  r1;
    logic [31:0] rb;     // card response bytes, first in MSB
    logic [7:0]  e_r1;
    logic [31:0] e_resp;
    bit          e_to;
    logic [7:0]  e_crc;  // expected last command byte, 0 = not tabulated
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;
  sd_cmd_seq_if bus();

  sd_cmd_seq #(.NCR_MAX(NCR_MAX), .INIT_BYTES(INIT_BYTES)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  int errors = 0, checks = 0;
  logic [7:0] exp_tx[NX];
  bit         exp_cs[NX];
  logic [7:0] rx_arr[NX];
  int         exp_n = 0;
  logic [7:0] cap_tx[NX];
  bit         cap_cs[NX];
  int         cap_cyc[NX];
  int         cap_n = 0;
  int         last_done_cyc = 0;
  int         ovl_err = 0, stab_err = 0;
  int         stray_req = 0, stray_ack = 0;
  int         lat_max = 3;
  vec_t       tbl[8];

  function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endfunction

  // CRC7 as the remainder of long division of the 40-bit message times x^7 by x^7+x^3+1.
  function automatic logic [6:0] crc7_ref(input logic [39:0] m);
    logic [46:0] r;
    r = {m, 7'd0};
    for (int i = 46; i >= 7; i--) if (r[i]) r[i -: 8] = r[i -: 8] ^ 8'h89;
    return r[6:0];
  endfunction

  task automatic push(input bit cs, input logic [7:0] tx, input logic [7:0] rx);
    exp_cs[exp_n] = cs; exp_tx[exp_n] = tx; rx_arr[exp_n] = rx;
    exp_n++;
  endtask

  function automatic void model_out(input vec_t v, output logic [7:0] r1, output logic [31:0] resp,
                                    output bit to);
    int rl;
    rl   = (v.len > 3'd4) ? 4 : int'(v.len);
    to   = (v.k >= NCR_MAX);
    r1   = to ? 8'hFF : v.r1;
    resp = 32'd0;
    if (!to) for (int j = 0; j < rl; j++) resp[31 - 8*j -: 8] = v.rb[31 - 8*j -: 8];
  endfunction

  // Expected wire-level transfer list (CS, tx) and the card's answer for each transfer.
  task automatic build(input vec_t v);
    logic [39:0] msg;
    int rl, np;
    bit to;
    rl  = (v.len > 3'd4) ? 4 : int'(v.len);
    msg = {2'b01, v.idx, v.arg};
    to  = (v.k >= NCR_MAX);
    np  = to ? NCR_MAX : v.k + 1;
    if (v.init) for (int i = 0; i < INIT_BYTES; i++) push(1'b1, 8'hFF, 8'hFF);
    push(1'b0, 8'hFF, 8'hFF);
    for (int i = 0; i < 5; i++) push(1'b0, msg[39 - 8*i -: 8], 8'hFF);
    push(1'b0, {crc7_ref(msg), 1'b1}, 8'hFF);
    for (int p = 0; p < np; p++) push(1'b0, 8'hFF, (!to && p == np - 1) ? v.r1 : 8'hFF);
    if (!to) for (int j = 0; j < rl; j++) push(1'b0, 8'hFF, v.rb[31 - 8*j -: 8]);
    push(1'b1, 8'hFF, 8'hFF);
  endtask

  // Card plus byte engine: one answer per stb, random latency, logs CS/tx of every transfer.
  initial begin : responder
    bit busy; int lat; logic [7:0] cur_tx; bit cur_cs; int cur_i;
    busy = 1'b0; lat = 0; cur_tx = 8'hFF; cur_cs = 1'b1; cur_i = 0;
    bus.i_byte_done = 1'b0;
    bus.i_byte_rx   = 8'hFF;
    forever begin
      @(posedge clk); #1;
      bus.i_byte_done = 1'b0;
      if (rst) busy = 1'b0;
      else if (bus.o_byte_stb) begin
        if (busy) ovl_err++;
        busy = 1'b1;
        lat = $urandom_range(0, lat_max);
        cur_tx = bus.o_byte_tx; cur_cs = bus.o_cs_n; cur_i = cap_n;
        if (cap_n < NX) begin
          cap_tx[cap_n] = cur_tx; cap_cs[cap_n] = cur_cs; cap_cyc[cap_n] = cyc;
          cap_n++;
        end
      end else if (busy) begin
        if (bus.o_byte_tx !== cur_tx || bus.o_cs_n !== cur_cs) stab_err++;
        if (lat == 0) begin
          bus.i_byte_done = 1'b1;
          bus.i_byte_rx   = rx_arr[cur_i];
          busy = 1'b0;
          last_done_cyc = cyc;
        end else lat--;
      end else if (stray_req != stray_ack) begin
        bus.i_byte_done = 1'b1;
        bus.i_byte_rx   = 8'h00;
        stray_ack++;
      end
    end
  end

  initial begin : watchdog
    #900000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk); #2;
  endtask

  task automatic drive_cmd(input vec_t v);
    bus.i_cmd_init = v.init; bus.i_cmd_idx = v.idx;
    bus.i_cmd_arg  = v.arg;  bus.i_resp_len = v.len;
  endtask

  task automatic issue(input vec_t v, output int acc);
    int b;
    b = 0;
    while (!bus.o_cmd_ready && b < 3000) begin step(); b++; end
    drive_cmd(v);
    bus.i_cmd_valid = 1'b1;
    acc = cyc;
    step();
    bus.i_cmd_valid = 1'b0;
  endtask

  task automatic wait_done(input string tag, output int d);
    int b;
    b = 0;
    while (!bus.o_done && b < 3000) begin step(); b++; end
    chk({tag, "_done_seen"}, bus.o_done, 1);
    d = cyc;
  endtask

  task automatic check_stream(input int start, input string tag);
    chk({tag, "_xfer_count"}, cap_n, exp_n);
    for (int i = start; i < exp_n && i < cap_n; i++) begin
      chk($sformatf("%s_tx[%0d]", tag, i - start), cap_tx[i], exp_tx[i]);
      chk($sformatf("%s_cs[%0d]", tag, i - start), cap_cs[i], exp_cs[i]);
    end
    chk({tag, "_stb_overlap"}, ovl_err, 0);
    chk({tag, "_tx_stable"}, stab_err, 0);
  endtask

  task automatic check_result(input string tag, input logic [7:0] er1, input logic [31:0] er,
                              input bit eto);
    chk({tag, "_r1"}, bus.o_r1, er1);
    chk({tag, "_resp"}, bus.o_resp, er);
    chk({tag, "_timeout"}, bus.o_timeout, eto);
  endtask

  task automatic run_one(input vec_t v, input logic [7:0] er1, input logic [31:0] er, input bit eto,
                         input logic [7:0] ecrc, input string tag);
    int start, acc, d;
    exp_n = cap_n;
    start = exp_n;
    build(v);
    issue(v, acc);
    wait_done(tag, d);
    check_result(tag, er1, er, eto);
    chk({tag, "_stb_lat"}, (cap_n > start) && ((cap_cyc[start] - acc) inside {[1:2]}), 1);
    chk({tag, "_done_lat"}, (d - last_done_cyc) inside {[1:2]}, 1);
    if (ecrc != 8'h00) chk({tag, "_crc_byte"}, cap_tx[start + (v.init ? INIT_BYTES : 0) + 6], ecrc);
    step();
    chk({tag, "_done_pulse"}, bus.o_done, 0);
    chk({tag, "_ready_after"}, bus.o_cmd_ready, 1);
    chk({tag, "_r1_hold"}, bus.o_r1, er1);
    check_stream(start, tag);
  endtask

  initial begin : main
    vec_t v, v2;
    logic [7:0] mr1;
    logic [31:0] mresp;
    bit mto;
    int start, acc, d, b, n_rst;

    rst = 1'b1;
    bus.i_cmd_valid = 1'b0;
    drive_cmd('{1'b0, 6'd0, 32'd0, 3'd0, 0, 8'd0, 32'd0, 8'd0, 32'd0, 1'b0, 8'd0});

    //            init idx    arg           len  k  r1     card rb       e_r1   e_resp        to    crc
    tbl[0] = '{1'b1, 6'd0,  32'h0000_0000, 3'd0, 1, 8'h01, 32'h0,        8'h01, 32'h0,        1'b0, 8'h95};
    tbl[1] = '{1'b0, 6'd8,  32'h0000_01AA, 3'd4, 0, 8'h01, 32'h0000_01AA, 8'h01, 32'h0000_01AA, 1'b0, 8'h87};
    tbl[2] = '{1'b0, 6'd17, 32'h1234_5678, 3'd0, 255, 8'h00, 32'h0,      8'hFF, 32'h0,        1'b1, 8'h00};
    tbl[3] = '{1'b0, 6'd55, 32'h0000_0000, 3'd0, 0, 8'h01, 32'h0,        8'h01, 32'h0,        1'b0, 8'h65};
    tbl[4] = '{1'b0, 6'd41, 32'h4000_0000, 3'd0, 1, 8'h00, 32'h0,        8'h00, 32'h0,        1'b0, 8'h77};
    tbl[5] = '{1'b0, 6'd58, 32'h0000_0000, 3'd7, 2, 8'h00, 32'hC0FF_8000, 8'h00, 32'hC0FF_8000, 1'b0, 8'hFD};
    tbl[6] = '{1'b0, 6'd8,  32'h0000_01AA, 3'd2, 0, 8'h01, 32'hAABB_0000, 8'h01, 32'hAABB_0000, 1'b0, 8'h87};
    tbl[7] = '{1'b0, 6'd1,  32'h0000_0000, 3'd0, NCR_MAX - 1, 8'h05, 32'h0, 8'h05, 32'h0,      1'b0, 8'hF9};

    repeat (3) step();
    rst = 1'b0;
    step();
    chk("rst_ready", bus.o_cmd_ready, 1);
    chk("rst_cs_n", bus.o_cs_n, 1);
    chk("rst_stb", bus.o_byte_stb, 0);
    chk("rst_done", bus.o_done, 0);
    chk("rst_timeout", bus.o_timeout, 0);
    chk("rst_r1", bus.o_r1, 8'hFF);
    chk("rst_resp", bus.o_resp, 0);
    chk("rst_tx", bus.o_byte_tx, 8'hFF);

    lat_max = 3;
    for (int i = 0; i < 8; i++)
      run_one(tbl[i], tbl[i].e_r1, tbl[i].e_resp, tbl[i].e_to, tbl[i].e_crc, $sformatf("tbl%0d", i));

    // Back-to-back CMD55 then CMD41 with valid held high throughout.
    v = tbl[3]; v2 = tbl[4];
    exp_n = cap_n; start = exp_n;
    build(v); build(v2);
    issue(v, acc);
    drive_cmd(v2);
    bus.i_cmd_valid = 1'b1;
    wait_done("b2b_a", d);
    check_result("b2b_a", v.e_r1, v.e_resp, v.e_to);
    step();
    chk("b2b_ready_after_done", bus.o_cmd_ready, 1);
    acc = cyc;
    step();
    bus.i_cmd_valid = 1'b0;
    chk("b2b_second_accepted", bus.o_cmd_ready, 0);
    wait_done("b2b_b", d);
    check_result("b2b_b", v2.e_r1, v2.e_resp, v2.e_to);
    chk("b2b_b_stb_lat", (cap_n > start + 9) && ((cap_cyc[start + 9] - acc) inside {[1:2]}), 1);
    step();
    check_stream(start, "b2b");

    // Reset while the fourth command byte is in flight.
    v = tbl[1];
    exp_n = cap_n; start = exp_n;
    build(v);
    issue(v, acc);
    b = 0;
    while (cap_n < start + 5 && b < 500) begin step(); b++; end
    chk("mid_rst_reached", cap_n >= start + 5, 1);
    rst = 1'b1;
    step();
    n_rst = cap_n;
    chk("mid_rst_cs_n", bus.o_cs_n, 1);
    chk("mid_rst_ready", bus.o_cmd_ready, 1);
    chk("mid_rst_stb", bus.o_byte_stb, 0);
    rst = 1'b0;
    stray_req++;
    repeat (8) step();
    chk("mid_rst_no_stb", cap_n, n_rst);
    chk("mid_rst_idle", bus.o_cmd_ready, 1);
    run_one(tbl[0], tbl[0].e_r1, tbl[0].e_resp, tbl[0].e_to, tbl[0].e_crc, "post_rst");

    // Random commands, random card behaviour, 0..20 cycle byte latency.
    lat_max = 20;
    for (int n = 0; n < 25; n++) begin
      v.init   = ($urandom_range(0, 3) == 0);
      v.idx    = 6'($urandom);
      v.arg    = $urandom;
      v.len    = 3'($urandom);
      v.k      = $urandom_range(0, NCR_MAX + 1);
      v.r1     = 8'($urandom) & 8'h7F;
      v.rb     = $urandom;
      v.e_crc  = 8'h00;
      model_out(v, mr1, mresp, mto);
      run_one(v, mr1, mresp, mto, 8'h00, $sformatf("rnd%0d", n));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
